// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, clock/baud defaults and
// the launch-to-done watchdog budget derived from them.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_t;

  localparam int unsigned MAIN_CLK_RATE  = 100_000_000;
  localparam int unsigned BAUD_CLK_RATE  = 115_200;
  localparam int unsigned BITS_PER_FRAME = 10;

  // One frame is start + 8 data + stop; the margin absorbs baud rounding and
  // serializer startup latency.
  localparam int unsigned FRAME_CYC          = BITS_PER_FRAME * (MAIN_CLK_RATE / BAUD_CLK_RATE);
  localparam int unsigned TIMEOUT_MARGIN_CYC = 3320;
  localparam int unsigned TIMEOUT_CYC_DEF    = FRAME_CYC + TIMEOUT_MARGIN_CYC;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Byte requester bundle: per-requester valid/data driven by the sources,
// one-hot ready returned by the arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx,
  output logic         any
);

  // Two linear passes (upper half from ptr, then wrap) avoid a modulo index.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && (j >= 32'(ptr)) && req[j]) begin
        gnt[j] = 1'b1;
        idx    = 3'(j);
        any    = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && (j < 32'(ptr)) && req[j]) begin
        gnt[j] = 1'b1;
        idx    = 3'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx serializer among N_REQ byte requesters: round-robin
// grant, one-cycle launch pulse, grant held until done or watchdog expiry.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          mclk,
  input  logic          mrst_n,
  uart_tx_arb_if.slave  req_if,
  output logic          tx_evt_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_done_i,
  output logic [2:0]    grant_id_o,
  output logic          busy_o,
  output logic          timeout_err_o
);

  arb_state_t       state_q, state_d;
  logic [2:0]       grant_q;
  logic [7:0]       data_q;
  logic [31:0]      wdog_q;
  logic [2:0]       rr_ptr;
  logic [N_REQ-1:0] win_gnt;
  logic [2:0]       win_idx;
  logic             win_any;
  logic [7:0]       win_byte;
  logic             accept;
  logic             wdog_hit;

  assign rr_ptr   = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
  assign accept   = (state_q == ST_IDLE) && win_any;
  assign wdog_hit = (wdog_q == TIMEOUT_CYC - 1);

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req (req_if.req_valid),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (win_idx == 3'(j)) win_byte = req_if.req_data[8*j +: 8];
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (win_any) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (tx_done_i || wdog_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_if.req_ready = (state_q == ST_IDLE) ? win_gnt : '0;
    tx_evt_o         = (state_q == ST_LAUNCH);
    busy_o           = (state_q != ST_IDLE);
    // done in the expiry cycle takes precedence, so no error is flagged
    timeout_err_o    = (state_q == ST_WAIT) && wdog_hit && !tx_done_i;
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      grant_q <= 3'(N_REQ - 1);
      data_q  <= '0;
      wdog_q  <= '0;
    end else begin
      if (accept) begin
        grant_q <= win_idx;
        data_q  <= win_byte;
      end
      if (state_q == ST_LAUNCH)    wdog_q <= '0;
      else if (state_q == ST_WAIT) wdog_q <= wdog_q + 32'd1;
    end
  end

  assign tx_data_o  = data_q;
  assign grant_id_o = grant_q;

endmodule
